// File: rtl/bresenham_pkg.sv
// Shared types and helpers for the Bresenham occupancy-grid ray tracer.
package bresenham_pkg;

    localparam int DEF_COORD_W   = 8;
    localparam int DEF_LOGODDS_W = 8;

    typedef enum logic [2:0] {IDLE, WAIT_OCC, SETUP, READ, WRITE} state_t;

    typedef logic [DEF_COORD_W-1:0]          coord_t;
    typedef logic signed [DEF_LOGODDS_W-1:0] logodds_t;

    function automatic int sat_add(input int a, input int inc, input int lo, input int hi);
        int s;
        s = a + inc;
        if (s > hi) return hi;
        if (s < lo) return lo;
        return s;
    endfunction

endpackage

// File: rtl/bresenham_stepper.sv
// Bresenham walk state: loads from endpoint/origin, steps one cell per advance toward the origin.
module bresenham_stepper #(
    parameter int COORD_W = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic               advance,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               last
);
    localparam int EW = COORD_W + 2;

    logic [COORD_W-1:0] adx, ady, rem, ld_adx, ld_ady, ld_max;
    logic               sx, sy;
    logic signed [EW-1:0] err;
    logic signed [EW:0]   e2, err_n;
    logic               step_x, step_y;

    always_comb begin
        ld_adx = (x0 >= x1) ? x0 - x1 : x1 - x0;
        ld_ady = (y0 >= y1) ? y0 - y1 : y1 - y0;
        ld_max = (ld_adx >= ld_ady) ? ld_adx : ld_ady;
        // e2 needs one more bit than err; both thresholds are taken from pre-update err
        e2     = {err, 1'b0};
        step_x = e2 > -$signed({3'b000, ady});
        step_y = e2 < $signed({3'b000, adx});
        err_n  = {err[EW-1], err};
        if (step_x) err_n = err_n - $signed({3'b000, ady});
        if (step_y) err_n = err_n + $signed({3'b000, adx});
    end

    assign last = (rem == COORD_W'(1));

    always_ff @(posedge clock) begin
        if (!reset) begin
            adx <= '0;
            ady <= '0;
            sx  <= 1'b0;
            sy  <= 1'b0;
            err <= '0;
            rem <= '0;
            x   <= '0;
            y   <= '0;
        end else if (load) begin
            adx <= ld_adx;
            ady <= ld_ady;
            sx  <= x0 > x1;
            sy  <= y0 > y1;
            err <= $signed({2'b00, ld_adx}) - $signed({2'b00, ld_ady});
            rem <= (ld_max == '0) ? COORD_W'(1) : ld_max;
            x   <= x1;
            y   <= y1;
        end else if (advance) begin
            if (step_x) x <= sx ? x + 1'b1 : x - 1'b1;
            if (step_y) y <= sy ? y + 1'b1 : y - 1'b1;
            err <= err_n[EW-1:0];
            rem <= rem - 1'b1;
        end
    end

endmodule

// File: rtl/bresenham_tracer.sv
// Ray tracer: read-modify-write log-odds update from endpoint back to (not including) origin.
// Define BRESENHAM_STATS_EN to add the cells_written / sat_events counters.
module bresenham_tracer
    import bresenham_pkg::*;
#(
    parameter int COORD_W   = DEF_COORD_W,
    parameter int LOGODDS_W = DEF_LOGODDS_W,
    parameter int L_OCC     = 9,
    parameter int L_FREE    = -3,
    parameter int L_MAX     = 127,
    parameter int L_MIN     = -128
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [COORD_W-1:0]     x0,
    input  logic [COORD_W-1:0]     y0,
    input  logic [COORD_W-1:0]     x1,
    input  logic [COORD_W-1:0]     y1,
    input  logic                   occupancy_busy,
    output logic                   busy,
    output logic                   done,
    output logic [2*COORD_W-1:0]   mem_addr,
    output logic                   mem_rd_en,
    input  logic [LOGODDS_W-1:0]   mem_rd_data,
    output logic                   mem_wr_en,
    output logic [LOGODDS_W-1:0]   mem_wr_data
`ifdef BRESENHAM_STATS_EN
    ,
    output logic [31:0]            cells_written,
    output logic [15:0]            sat_events
`endif
);
    state_t             state;
    logic [COORD_W-1:0] cx0, cy0, cx1, cy1, cur_x, cur_y;
    logic               first, last;
    int                 inc, clamped;

    bresenham_stepper #(.COORD_W(COORD_W)) u_stepper (
        .clock   (clock),
        .reset   (reset),
        .load    (state == SETUP),
        .advance (state == WRITE),
        .x0      (cx0),
        .y0      (cy0),
        .x1      (cx1),
        .y1      (cy1),
        .x       (cur_x),
        .y       (cur_y),
        .last    (last)
    );

    // Read data arrives in the WRITE cycle, so the write value is combinational
    always_comb begin
        inc     = first ? L_OCC : L_FREE;
        clamped = sat_add(int'($signed(mem_rd_data)) + 0, inc, L_MIN, L_MAX);
    end

    assign mem_wr_data = mem_wr_en ? LOGODDS_W'(clamped) : '0;
    assign mem_addr    = {cur_y, cur_x};

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            first     <= 1'b0;
            cx0       <= '0;
            cy0       <= '0;
            cx1       <= '0;
            cy1       <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    cx0   <= x0;
                    cy0   <= y0;
                    cx1   <= x1;
                    cy1   <= y1;
                    busy  <= 1'b1;
                    state <= occupancy_busy ? WAIT_OCC : SETUP;
                end
                WAIT_OCC: if (!occupancy_busy) state <= SETUP;
                SETUP: begin
                    first     <= 1'b1;
                    mem_rd_en <= 1'b1;
                    state     <= READ;
                end
                READ: begin
                    mem_rd_en <= 1'b0;
                    mem_wr_en <= 1'b1;
                    done      <= last;
                    state     <= WRITE;
                end
                WRITE: begin
                    mem_wr_en <= 1'b0;
                    done      <= 1'b0;
                    first     <= 1'b0;
                    if (done) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        mem_rd_en <= 1'b1;
                        state     <= READ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BRESENHAM_STATS_EN
    int raw_sum;
    assign raw_sum = int'($signed(mem_rd_data)) + inc;

    always_ff @(posedge clock) begin
        if (!reset) begin
            cells_written <= '0;
            sat_events    <= '0;
        end else if (mem_wr_en) begin
            if (cells_written != '1) cells_written <= cells_written + 1'b1;
            if (clamped != raw_sum) sat_events <= sat_events + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_bresenham_tracer.sv
// Scoreboarded bench: a line-walk model queues expected writes, a monitor checks each DUT write.
module tb_bresenham_tracer;
    localparam int L_OCC = 9, L_FREE = -3, L_MAX = 127, L_MIN = -128;

    logic        clock = 1'b0, reset = 1'b0, start = 1'b0, occupancy_busy = 1'b0;
    logic [7:0]  x0 = '0, y0 = '0, x1 = '0, y1 = '0;
    logic        busy, done, mem_rd_en, mem_wr_en;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rd_data, mem_wr_data;
`ifdef BRESENHAM_STATS_EN
    logic [31:0] cells_written;
    logic [15:0] sat_events;
`endif

    always #5 clock = ~clock;

    bresenham_tracer dut (
        .clock(clock), .reset(reset), .start(start),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1),
        .occupancy_busy(occupancy_busy),
        .busy(busy), .done(done),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data)
`ifdef BRESENHAM_STATS_EN
        , .cells_written(cells_written), .sat_events(sat_events)
`endif
    );

    logic [7:0] tb_mem [0:65535];
    logic [7:0] shadow [0:65535];

    typedef struct { int addr; int inc; bit last; } exp_t;
    exp_t sb[$];
    int n_cmp = 0, n_bad = 0, n_writes = 0;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    function automatic int clamp(input int v);
        return (v > L_MAX) ? L_MAX : (v < L_MIN) ? L_MIN : v;
    endfunction

    // 1-cycle-latency map RAM
    always @(posedge clock) begin
        if (mem_rd_en) mem_rd_data <= tb_mem[mem_addr];
        if (mem_wr_en) tb_mem[mem_addr] = mem_wr_data;
    end

    always @(negedge clock) begin
        exp_t e;
        int want;
        if (reset && mem_wr_en) begin
            n_writes++;
            if (sb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_write: addr %0d, none expected", mem_addr);
            end else begin
                e = sb.pop_front();
                want = clamp(int'($signed(shadow[e.addr])) + e.inc);
                check("wr_addr", int'(mem_addr), e.addr);
                check("wr_data", int'($signed(mem_wr_data)), want);
                check("done_on_last", int'(done), int'(e.last));
                shadow[e.addr] = 8'(want);
            end
        end else if (reset && done) begin
            n_cmp++; n_bad++;
            $display("FAIL done_without_write: done=%0d, want 0", done);
        end
    end

    // Walk the ray from endpoint to origin; every cell but the origin is written
    task automatic push_trace(input int ox, input int oy, input int ex, input int ey, output int n);
        int x, y, dx, dy, sx, sy, err, e2;
        exp_t e;
        x = ex; y = ey; n = 0;
        dx = (ox > ex) ? ox - ex : ex - ox;
        dy = (oy > ey) ? oy - ey : ey - oy;
        sx = (ox > ex) ? 1 : -1;
        sy = (oy > ey) ? 1 : -1;
        err = dx - dy;
        if (x == ox && y == oy) begin
            e.addr = y * 256 + x; e.inc = L_OCC; e.last = 1'b1;
            sb.push_back(e);
            n = 1;
            return;
        end
        while (!(x == ox && y == oy) && n < 600) begin
            e.addr = y * 256 + x; e.inc = (n == 0) ? L_OCC : L_FREE; e.last = 1'b0;
            sb.push_back(e);
            n++;
            e2 = 2 * err;
            if (e2 > -dy) begin err -= dy; x += sx; end
            if (e2 < dx) begin err += dx; y += sy; end
        end
        e = sb.pop_back();
        e.last = 1'b1;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic preload(input int addr, input int v);
        tb_mem[addr] = 8'(v);
        shadow[addr] = 8'(v);
    endtask

    // Called at a tick with the DUT idle; returns at the first tick with busy low
    task automatic run_trace(input int ox, input int oy, input int ex, input int ey, input int occ);
        int n, busy_cnt, first_rd;
        push_trace(ox, oy, ex, ey, n);
        x0 = 8'(ox); y0 = 8'(oy); x1 = 8'(ex); y1 = 8'(ey);
        start = 1'b1;
        occupancy_busy = (occ > 0);
        busy_cnt = 0;
        first_rd = -1;
        for (int c = 1; c < 4000; c++) begin
            tick();
            start = 1'b0;
            if (busy) busy_cnt++;
            if (c <= occ) check("occ_hold_no_access", int'(mem_rd_en | mem_wr_en), 0);
            if (mem_rd_en && first_rd < 0) first_rd = c;
            occupancy_busy = (c < occ);
            if (!busy) break;
        end
        check("busy_cycles", busy_cnt, occ + 1 + 2 * n);
        check("first_read_cycle", first_rd, occ + 2);
        check("sb_drained", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        int n;
        for (int i = 0; i < 65536; i++) begin
            tb_mem[i] = '0;
            shadow[i] = '0;
        end
        repeat (3) tick();
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_rd_en", int'(mem_rd_en), 0);
        check("rst_wr_en", int'(mem_wr_en), 0);
        check("rst_addr", int'(mem_addr), 0);
        check("rst_wr_data", int'(mem_wr_data), 0);
        reset = 1'b1;
        tick();

        run_trace(0, 0, 3, 1, 0);
        check("t1_end_3_1", int'($signed(tb_mem[1 * 256 + 3])), 9);
        check("t1_free_2_1", int'($signed(tb_mem[1 * 256 + 2])), -3);
        check("t1_free_1_0", int'($signed(tb_mem[0 * 256 + 1])), -3);
        check("t1_origin_untouched", int'($signed(tb_mem[0])), 0);

        preload(5 * 256 + 5, 120);
        run_trace(5, 5, 5, 5, 0);
        check("t2_saturated", int'($signed(tb_mem[5 * 256 + 5])), 127);
`ifdef BRESENHAM_STATS_EN
        check("t2_sat_events", int'(sat_events), 1);
`endif

        run_trace(10, 2, 2, 10, 0);
        check("t3_origin_untouched", int'($signed(tb_mem[2 * 256 + 10])), 0);
        check("t3_diag_9_3", int'($signed(tb_mem[3 * 256 + 9])), -3);

        run_trace(0, 40, 3, 42, 4);

        preload(20 * 256 + 1, -127);
        run_trace(0, 20, 2, 20, 0);
        check("t5_floor_first", int'($signed(tb_mem[20 * 256 + 1])), -128);
        run_trace(0, 20, 2, 20, 0);
        check("t5_floor_second", int'($signed(tb_mem[20 * 256 + 1])), -128);

        // Reset during the second WRITE of a 5-cell trace
        push_trace(0, 60, 5, 62, n);
        check("t6_len", n, 5);
        x0 = 8'd0; y0 = 8'd60; x1 = 8'd5; y1 = 8'd62;
        start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            start = 1'b0;
        end
        check("t6_in_second_write", int'(mem_wr_en), 1);
        reset = 1'b0;
        tick();
        check("t6_busy_after_rst", int'(busy), 0);
        check("t6_wr_after_rst", int'(mem_wr_en), 0);
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("t6_no_more_writes", int'(mem_wr_en), 0);
        end
        check("t6_abandoned_left", sb.size(), 3);
        sb.delete();
        check("t6_untouched_3_61", int'($signed(tb_mem[61 * 256 + 3])), 0);
        run_trace(0, 70, 4, 71, 0);

        for (int i = 0; i < 65536; i++) preload(i, int'($urandom_range(0, 255)));
        for (int t = 0; t < 30; t++)
            run_trace(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                      int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                      int'($urandom_range(0, 3)));
        run_trace(100, 100, 100, 100, 1);
        run_trace(37, 200, 41, 3, 0);
`ifdef BRESENHAM_STATS_EN
        check("cells_written", int'(cells_written), n_writes);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
